// File: rtl/mips_multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS core:
// opcode/funct constants, ALU operation encoding and FSM states.
package mips_multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_multicycle_alu.sv
// Shared 32-bit combinational ALU of the multi-cycle core.
// The zero flag drives the beq decision.
module mips_mc_alu
    import mips_multicycle_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y,
    output logic        o_zero
);

    // Operation select; arithmetic wraps modulo 2^32, slt is signed
    always_comb begin
        o_y = '0;
        unique case (i_op)
            ALU_ADD:   o_y = i_a + i_b;
            ALU_SUB:   o_y = i_a - i_b;
            ALU_AND:   o_y = i_a & i_b;
            ALU_OR:    o_y = i_a | i_b;
            ALU_SLT:   o_y = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_PASSB: o_y = i_b;
            default:   o_y = '0;
        endcase
    end

    assign o_zero = (o_y == 32'd0);

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB FSM, shared ALU,
// stalling data-memory handshake. Define MIPS_MC_JUMP_EN to decode j.
module mips_multicycle
    import mips_multicycle_pkg::*;
#(
    parameter int          IMEM_AW  = 5,
    parameter int          DMEM_AW  = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ready,
    output logic [31:0]        pc_out,
    output logic               illegal
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_target;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;
    logic [31:0] r_gpr [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_sext;

    logic        w_funct_ok;
    logic        w_is_r;
    logic        w_is_ori;
    logic        w_is_lui;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_is_j;
    logic        w_legal;

    alu_op_e     w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic        w_alu_zero;

    logic [4:0]  w_wb_dst;
    logic [31:0] w_wb_data;
    logic        w_illegal;
    logic        w_we;
    logic        w_re;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_imm   = r_ir[15:0];
    assign w_sext  = sext16(w_imm);

    assign w_funct_ok = (w_funct == FN_ADDU) || (w_funct == FN_SUBU) ||
                        (w_funct == FN_AND)  || (w_funct == FN_OR)   ||
                        (w_funct == FN_SLT);

    assign w_is_r   = (w_op == OP_RTYPE) && w_funct_ok;
    assign w_is_ori = (w_op == OP_ORI);
    assign w_is_lui = (w_op == OP_LUI);
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_beq = (w_op == OP_BEQ);
`ifdef MIPS_MC_JUMP_EN
    assign w_is_j   = (w_op == OP_J);
`else
    assign w_is_j   = 1'b0;
`endif
    assign w_legal  = w_is_r | w_is_ori | w_is_lui | w_is_lw |
                      w_is_sw | w_is_beq | w_is_j;

    // ALU operation and second operand chosen from the held instruction
    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_b  = r_b;
        unique case (1'b1)
            w_is_r: begin
                unique case (w_funct)
                    FN_SUBU: w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            w_is_ori: begin
                w_alu_op = ALU_OR;
                w_alu_b  = {16'd0, w_imm};
            end
            w_is_lui: begin
                w_alu_op = ALU_PASSB;
                w_alu_b  = {w_imm, 16'd0};
            end
            w_is_lw, w_is_sw: begin
                w_alu_op = ALU_ADD;
                w_alu_b  = w_sext;
            end
            w_is_beq: w_alu_op = ALU_SUB;
            default: ;
        endcase
    end

    mips_mc_alu u_alu (
        .i_op   (w_alu_op),
        .i_a    (r_a),
        .i_b    (w_alu_b),
        .o_y    (w_alu_y),
        .o_zero (w_alu_zero)
    );

    assign w_wb_dst  = w_is_r ? w_rd : w_rt;
    assign w_wb_data = w_is_lw ? r_mdr : r_aluout;

    // Next-state and per-state control outputs
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        w_we      = 1'b0;
        w_re      = 1'b0;
        case (r_state)
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_legal) begin
                    w_next = ST_EXEC;
                end else begin
                    w_next    = ST_FETCH;
                    w_illegal = 1'b1;
                end
            end
            ST_EXEC: begin
                if (w_is_lw || w_is_sw)
                    w_next = ST_MEM;
                else if (w_is_beq || w_is_j)
                    w_next = ST_FETCH;
                else
                    w_next = ST_WB;
            end
            ST_MEM: begin
                w_we = w_is_sw;
                w_re = w_is_lw;
                if (dmem_ready)
                    w_next = w_is_lw ? ST_WB : ST_FETCH;
            end
            ST_WB:   w_next = ST_FETCH;
            default: w_next = ST_FETCH;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_FETCH;
        else
            r_state <= w_next;
    end

    // Datapath registers and register file, updated by state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_target <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            for (int i = 0; i < 32; i++)
                r_gpr[i] <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir <= imem_rdata;
                    r_pc <= r_pc + 32'd4;
                end
                ST_DECODE: begin
                    r_a      <= r_gpr[w_rs];
                    r_b      <= r_gpr[w_rt];
                    r_target <= r_pc + {w_sext[29:0], 2'b00};
                end
                ST_EXEC: begin
                    r_aluout <= w_alu_y;
                    if (w_is_beq && w_alu_zero)
                        r_pc <= r_target;
                    if (w_is_j)
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                end
                ST_MEM: begin
                    if (dmem_ready && w_is_lw)
                        r_mdr <= dmem_rdata;
                end
                ST_WB: begin
                    if (w_wb_dst != 5'd0)
                        r_gpr[w_wb_dst] <= w_wb_data;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = r_pc[IMEM_AW+1:2];
    assign dmem_addr  = r_aluout[DMEM_AW+1:2];
    assign dmem_wdata = r_b;
    assign dmem_we    = w_we;
    assign dmem_re    = w_re;
    assign pc_out     = r_pc;
    assign illegal    = w_illegal;

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multi-cycle MIPS core that replaces the single-cycle datapath with a five-state control FSM, shared ALU, registered IR/PC and a wait-state data-memory handshake. Parametrised in memory address widths and reset vector. Sits at the processor top, between a combinational instruction ROM and a data memory that may stall.

## Interface
- IMEM_AW, 5, instruction-memory word-address width
- DMEM_AW, 5, data-memory word-address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- imem_addr  out  IMEM_AW  word address, equals PC[IMEM_AW+1:2]
- imem_rdata  in  32  instruction, combinational from imem_addr
- dmem_addr  out  DMEM_AW  word address, ALU result [DMEM_AW+1:2]
- dmem_wdata  out  32  store data (rt)
- dmem_we  out  1  store request, held until accepted
- dmem_re  out  1  load request, held until accepted
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  access accepted this cycle
- pc_out  out  32  current PC
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- Clock and reset: one clock `Clk`; `Reset` asynchronous, active-high.

## Operation
- ISA: addu, subu, and, or, slt (R-type); ori, lui, lw, sw, beq; j (config-gated).
- States: FETCH -> DECODE -> EXEC -> {MEM | WB | FETCH}; MEM -> WB (lw) or FETCH (sw).
- FETCH: IR <= imem_rdata; PC <= PC+4.
- DECODE: A <= GPR[rs], B <= GPR[rt]; beq target = PC + (sext(imm)<<2) precomputed.
- EXEC: R-type/ori/lui -> ALUOut, go WB; lw/sw -> address = A + sext(imm), go MEM; beq: if A==B PC <= target, go FETCH; j: PC <= {PC[31:28], idx, 2'b00}, go FETCH.
- ori zero-extends; lui places imm in [31:16]; arithmetic wraps modulo 2^32; slt signed.
- MEM: assert dmem_re or dmem_we; stay until dmem_ready=1; lw latches dmem_rdata into MDR.
- WB: write rd (R-type) or rt (I-type); writes to $0 ignored, $0 reads 0.
- Illegal op in DECODE: pulse illegal, treat as NOP, go FETCH.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IR=0, all GPRs=0, dmem_we/re=0, illegal=0.
- Latency (zero wait): beq/j 3 cycles, R-type/ori/lui/sw 4, lw 5; each dmem_ready=0 cycle adds one.
- dmem_addr/wdata stable while request high; request drops the cycle after ready.
- Reset mid-MEM: request drops immediately (async), no register write occurs.
- Branch to self: legal, loops indefinitely.
- PC increments past IMEM range wrap via address truncation.

## Configuration
- MIPS_MC_JUMP_EN defined: j decoded as above.
- Undefined: opcode 6'h02 is illegal (pulse, NOP).

## Structure
- Shared package: opcode/funct constants, ALU op encoding, FSM state enum.
- One sub-module: mips_mc_alu (combinational, 32-bit, zero flag); GPR stays inline.

## Test plan
- Reset with RESET_PC=32'h40 -> pc_out=32'h40 after release; first imem_addr=5'h10.
- ori $1,$0,0x1234; addu $2,$1,$1 -> $2=32'h2468 after 8 cycles.
- sw $2,4($0) with dmem_ready low 3 cycles -> dmem_we held 4 cycles, addr=1, wdata=32'h2468; lw $3,4($0) -> $3=32'h2468.
- beq $1,$1,-1 -> PC stays constant, 3 cycles per iteration.
- Opcode 6'h3F -> illegal pulses one cycle, no GPR/memory change, next fetch at PC+4.
- j 0x10 with MIPS_MC_JUMP_EN -> PC=32'h40; without it -> illegal pulse, PC+4.
